dem_xuong_timer: RTL and testbench

//   Loadable down-counter/timer, the count-down counterpart of the team's 4-bit up counter.

---
 rtl/dem_xuong_timer.sv | 92 +++++++++
 tb/tb_dem_xuong_timer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dem_xuong_timer.sv
// Loadable down-counter/timer: counts a loaded value down to zero and pulses done.
// With auto-reload enabled it becomes a periodic tick generator.
module dem_xuong_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clki,
  input  logic             rs,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_rl,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      q_d      = din;
      reload_d = din;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (q_q != '0)) state_d = RUN;
        end
        RUN: begin
          if (!pause) begin
            if (q_q > WIDTH'(1)) begin
              q_d = q_q - WIDTH'(1);
            end else if (q_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (auto_rl && (reload_q != '0)) begin
                q_d = reload_q;
              end else begin
                q_d     = '0;
                state_d = DONE;
              end
            end else begin
              // q==0 in RUN is unreachable; settle safely without a done pulse
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (start && (reload_q != '0)) begin
            q_d     = reload_q;
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_dem_xuong_timer.sv
// Directed bench for dem_xuong_timer: load, one-shot count, auto-reload,
// pause, zero load, load abort and asynchronous reset mid-run.
module tb_dem_xuong_timer;

  logic       clki = 1'b0;
  logic       rs;
  logic       load;
  logic [3:0] din;
  logic       start;
  logic       pause;
  logic       auto_rl;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  dem_xuong_timer #(.WIDTH(4)) dut (
    .clki    (clki),
    .rs      (rs),
    .load    (load),
    .din     (din),
    .start   (start),
    .pause   (pause),
    .auto_rl (auto_rl),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  always #5 clki = ~clki;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int eq, input int eb, input int ed);
    chk({tag, ".q"}, {28'd0, q}, eq);
    chk({tag, ".busy"}, {31'd0, busy}, eb);
    chk({tag, ".done"}, {31'd0, done}, ed);
  endtask

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  initial begin
    rs = 1'b0; load = 1'b0; din = 4'd0; start = 1'b0; pause = 1'b0; auto_rl = 1'b0;

    // 1. reset
    #2;
    expect_out("rst_async", 0, 0, 0);
    #10;
    rs = 1'b1;
    tick();
    expect_out("rst_rel", 0, 0, 0);

    // 2. one-shot count of 5
    load = 1'b1; din = 4'd5; tick(); load = 1'b0;
    expect_out("os_load", 5, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    expect_out("os_start", 5, 1, 0);
    tick(); expect_out("os_4", 4, 1, 0);
    tick(); expect_out("os_3", 3, 1, 0);
    tick(); expect_out("os_2", 2, 1, 0);
    tick(); expect_out("os_1", 1, 1, 0);
    tick(); expect_out("os_0", 0, 0, 1);
    tick(); expect_out("os_hold", 0, 0, 0);

    // 3. auto-reload of 3, then drop auto_rl mid-run
    load = 1'b1; din = 4'd3; auto_rl = 1'b1; tick(); load = 1'b0;
    expect_out("ar_load", 3, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    expect_out("ar_start", 3, 1, 0);
    tick(); expect_out("ar_2a", 2, 1, 0);
    tick(); expect_out("ar_1a", 1, 1, 0);
    tick(); expect_out("ar_rl1", 3, 1, 1);
    tick(); expect_out("ar_2b", 2, 1, 0);
    tick(); expect_out("ar_1b", 1, 1, 0);
    tick(); expect_out("ar_rl2", 3, 1, 1);
    tick(); expect_out("ar_2c", 2, 1, 0);
    auto_rl = 1'b0;
    tick(); expect_out("ar_1c", 1, 1, 0);
    tick(); expect_out("ar_stop", 0, 0, 1);
    tick(); expect_out("ar_done", 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    expect_out("done_restart", 3, 1, 0);

    // 4. pause for two edges at q=4 (load aborts the running count)
    load = 1'b1; din = 4'd6; tick(); load = 1'b0;
    expect_out("pz_load", 6, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    expect_out("pz_start", 6, 1, 0);
    tick(); expect_out("pz_5", 5, 1, 0);
    tick(); expect_out("pz_4", 4, 1, 0);
    pause = 1'b1; start = 1'b1;
    tick(); expect_out("pz_hold1", 4, 1, 0);
    tick(); expect_out("pz_hold2", 4, 1, 0);
    pause = 1'b0; start = 1'b0;
    tick(); expect_out("pz_3", 3, 1, 0);
    tick(); expect_out("pz_2", 2, 1, 0);
    tick(); expect_out("pz_1", 1, 1, 0);
    tick(); expect_out("pz_0", 0, 0, 1);
    tick(); expect_out("pz_after", 0, 0, 0);

    // 5. zero load: start ignored
    load = 1'b1; din = 4'd0; tick(); load = 1'b0;
    expect_out("z_load", 0, 0, 0);
    start = 1'b1; tick();
    expect_out("z_start", 0, 0, 0);
    tick(); start = 1'b0;
    expect_out("z_start2", 0, 0, 0);

    // 6a. load with start on the same edge aborts at q=5
    load = 1'b1; din = 4'd9; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    expect_out("ab_start", 9, 1, 0);
    tick(); tick(); tick(); tick();
    expect_out("ab_5", 5, 1, 0);
    load = 1'b1; din = 4'd2; start = 1'b1; tick(); load = 1'b0; start = 1'b0;
    expect_out("ab_load", 2, 0, 0);
    tick(); expect_out("ab_idle", 2, 0, 0);

    // 6b. asynchronous reset mid-run at q=5
    load = 1'b1; din = 4'd9; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    expect_out("mr_5", 5, 1, 0);
    rs = 1'b0; #1;
    expect_out("mr_async", 0, 0, 0);
    #2; rs = 1'b1;
    tick(); expect_out("mr_rel", 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    expect_out("mr_start0", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
